// File: rtl/rx_buf_pkg.sv
// rx_buf_pkg: capture state encoding and word-order constants shared by the RX I/Q buffer
package rx_buf_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, CAP_I = 2'd1, CAP_Q = 2'd2, CAP_H = 2'd3} cap_state_t;
    localparam int WORDS_PER_SAMPLE = 3;
    localparam int WORD_W = 16;
    localparam cap_state_t FIRST_WORD = CAP_I;
    localparam cap_state_t LAST_WORD = CAP_H;
    function automatic cap_state_t next_word(input cap_state_t s);
        return s == LAST_WORD ? IDLE : cap_state_t'(s + 2'd1);
    endfunction
endpackage

// File: rtl/rx_word_fifo.sv
// rx_word_fifo: synchronous word FIFO with level count and registered read
module rx_word_fifo
    import rx_buf_pkg::*;
#(
    parameter int DEPTH = 2048,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic              adc_clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic [WORD_W-1:0] wdata,
    input  logic              pop,
    output logic [WORD_W-1:0] pop_data,
    output logic              pop_valid,
    output logic [AW:0]       level,
    output logic [AW:0]       level_nxt
);
    logic [WORD_W-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic pop_ok;
    assign pop_ok = pop && level != '0;
    assign level_nxt = level + (AW+1)'(we) - (AW+1)'(pop_ok);
    always_ff @(posedge adc_clk) begin
        if (we && reset_n) mem[wp] <= wdata;
    end
    always_ff @(posedge adc_clk) begin
        if (!reset_n) begin
            wp <= '0;
            rp <= '0;
            level <= '0;
            pop_valid <= 1'b0;
            pop_data <= '0;
        end else begin
            wp <= wp + AW'(we);
            rp <= rp + AW'(pop_ok);
            level <= level_nxt;
            pop_valid <= pop_ok;
            if (pop_ok) pop_data <= mem[rp];
        end
    end
endmodule

// File: rtl/rx_iq_buffer.sv
// rx_iq_buffer: walks the RX read mux through I, Q and packed-high words and buffers whole samples
module rx_iq_buffer
    import rx_buf_pkg::*;
#(
    parameter int DEPTH = 2048,
    parameter int FRAME_WORDS = 1530,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic              adc_clk,
    input  logic              reset_n,
    input  logic              rx_avail_A,
    input  logic [WORD_W-1:0] rx_dout_A,
    output logic              rd_i,
    output logic              rd_q,
    input  logic              pop,
    output logic [WORD_W-1:0] pop_data,
    output logic              pop_valid,
    output logic [AW:0]       level,
    output logic              frame_rdy,
    output logic              ovf,
    input  logic              clr_ovf
);
    cap_state_t state;
    logic [AW:0] level_nxt;
    logic space_ok, miss;
    // Room for a whole sample is reserved up front; pops mid-capture only add space
    assign space_ok = (AW+1)'(DEPTH) - level >= (AW+1)'(WORDS_PER_SAMPLE);
    assign miss = rx_avail_A && (state != IDLE || !space_ok);
    assign rd_i = state == CAP_I;
    assign rd_q = state == CAP_Q;
    rx_word_fifo #(.DEPTH(DEPTH)) u_fifo (
        .adc_clk(adc_clk),
        .reset_n(reset_n),
        .we(state != IDLE),
        .wdata(rx_dout_A),
        .pop(pop),
        .pop_data(pop_data),
        .pop_valid(pop_valid),
        .level(level),
        .level_nxt(level_nxt)
    );
    always_ff @(posedge adc_clk) begin
        if (!reset_n) begin
            state <= IDLE;
            ovf <= 1'b0;
            frame_rdy <= 1'b0;
        end else begin
            state <= state == IDLE ? (rx_avail_A && space_ok ? FIRST_WORD : IDLE) : next_word(state);
            ovf <= miss || (ovf && !clr_ovf);
            frame_rdy <= level_nxt >= (AW+1)'(FRAME_WORDS);
        end
    end
endmodule

// File: tb/tb_rx_iq_buffer.sv
// tb_rx_iq_buffer: directed checks of capture sequencing, FIFO order, overflow and frame flags
module tb_rx_iq_buffer;
    localparam int DEPTH = 16;
    localparam int FRAME_WORDS = 6;
    logic adc_clk = 1'b0;
    logic reset_n, rx_avail_A, rd_i, rd_q, pop, pop_valid, frame_rdy, ovf, clr_ovf;
    logic [15:0] rx_dout_A, pop_data;
    logic [4:0] level;
    logic [23:0] si, sq;
    logic [15:0] exp_q [$];
    int tests = 0;
    int fails = 0;

    always #5 adc_clk = ~adc_clk;
    // RX read-mux model: I low, Q low, or packed high bytes
    assign rx_dout_A = rd_i ? si[15:0] : rd_q ? sq[15:0] : {si[23:16], sq[23:16]};

    rx_iq_buffer #(.DEPTH(DEPTH), .FRAME_WORDS(FRAME_WORDS)) dut (
        .adc_clk(adc_clk),
        .reset_n(reset_n),
        .rx_avail_A(rx_avail_A),
        .rx_dout_A(rx_dout_A),
        .rd_i(rd_i),
        .rd_q(rd_q),
        .pop(pop),
        .pop_data(pop_data),
        .pop_valid(pop_valid),
        .level(level),
        .frame_rdy(frame_rdy),
        .ovf(ovf),
        .clr_ovf(clr_ovf)
    );

    task automatic tick();
        @(posedge adc_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic [23:0] i, input logic [23:0] q);
        si = i;
        sq = q;
        exp_q.push_back(i[15:0]);
        exp_q.push_back(q[15:0]);
        exp_q.push_back({i[23:16], q[23:16]});
        rx_avail_A = 1'b1;
        tick();
        rx_avail_A = 1'b0;
    endtask

    task automatic sample(input logic [23:0] i, input logic [23:0] q);
        strobe(i, q);
        repeat (3) tick();
    endtask

    task automatic pop_chk(input string tag);
        logic [15:0] w;
        w = exp_q.pop_front();
        chk({tag, " valid"}, 32'(pop_valid), 1);
        chk({tag, " data"}, 32'(pop_data), 32'(w));
    endtask

    task automatic drain(input int n, input string tag);
        pop = 1'b1;
        for (int k = 0; k < n; k++) begin
            tick();
            pop_chk(tag);
        end
        pop = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        rx_avail_A = 1'b0;
        pop = 1'b0;
        clr_ovf = 1'b0;
        si = '0;
        sq = '0;
        tick();
        tick();
        chk("rst level", 32'(level), 0);
        chk("rst ovf", 32'(ovf), 0);
        chk("rst rd_i", 32'(rd_i), 0);
        chk("rst rd_q", 32'(rd_q), 0);
        chk("rst pop_valid", 32'(pop_valid), 0);
        chk("rst frame_rdy", 32'(frame_rdy), 0);
        chk("rst pop_data", 32'(pop_data), 0);
        reset_n = 1'b1;

        strobe(24'h123456, 24'hABCDEF);
        chk("cap_i rd_i", 32'(rd_i), 1);
        chk("cap_i rd_q", 32'(rd_q), 0);
        chk("cap_i level", 32'(level), 0);
        tick();
        chk("cap_q rd_i", 32'(rd_i), 0);
        chk("cap_q rd_q", 32'(rd_q), 1);
        chk("cap_q level", 32'(level), 1);
        tick();
        chk("cap_h rd_i", 32'(rd_i), 0);
        chk("cap_h rd_q", 32'(rd_q), 0);
        chk("cap_h level", 32'(level), 2);
        tick();
        chk("idle level", 32'(level), 3);
        chk("idle rd_i", 32'(rd_i), 0);
        exp_q.delete();
        pop = 1'b1;
        tick();
        chk("pop0 valid", 32'(pop_valid), 1);
        chk("pop0 data", 32'(pop_data), 32'h3456);
        tick();
        chk("pop1 data", 32'(pop_data), 32'hCDEF);
        tick();
        chk("pop2 data", 32'(pop_data), 32'h12AB);
        chk("pop2 level", 32'(level), 0);
        pop = 1'b0;
        tick();
        chk("pop idle valid", 32'(pop_valid), 0);
        pop = 1'b1;
        tick();
        pop = 1'b0;
        chk("empty pop valid", 32'(pop_valid), 0);
        chk("empty pop data hold", 32'(pop_data), 32'h12AB);
        chk("empty pop level", 32'(level), 0);

        sample(24'h000001, 24'h000002);
        chk("fill l3", 32'(level), 3);
        chk("fill l3 frame", 32'(frame_rdy), 0);
        strobe(24'h0A0B0C, 24'h0D0E0F);
        tick();
        tick();
        chk("frame l5 level", 32'(level), 5);
        chk("frame l5 low", 32'(frame_rdy), 0);
        tick();
        chk("frame l6 level", 32'(level), 6);
        tick();
        chk("frame l6 high", 32'(frame_rdy), 1);
        sample(24'h102030, 24'h405060);
        sample(24'hA1B2C3, 24'hD4E5F6);
        sample(24'hFFEEDD, 24'h998877);
        chk("fill l15", 32'(level), 15);
        rx_avail_A = 1'b1;
        tick();
        rx_avail_A = 1'b0;
        chk("drop rd_i", 32'(rd_i), 0);
        chk("drop ovf", 32'(ovf), 1);
        chk("drop level", 32'(level), 15);
        tick();
        chk("drop level hold", 32'(level), 15);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("clr ovf", 32'(ovf), 0);
        drain(2, "fill pop");
        chk("fill l13", 32'(level), 13);
        sample(24'h5A5A5A, 24'hA5A5A5);
        chk("fill l16", 32'(level), 16);
        chk("fill ovf clear", 32'(ovf), 0);
        drain(16, "fill drain");
        chk("fill empty", 32'(level), 0);
        tick();
        chk("frame low empty", 32'(frame_rdy), 0);
        chk("drain end valid", 32'(pop_valid), 0);

        strobe(24'h111111, 24'h222222);
        tick();
        rx_avail_A = 1'b1;
        tick();
        rx_avail_A = 1'b0;
        chk("miss ovf", 32'(ovf), 1);
        chk("miss rd_q", 32'(rd_q), 0);
        chk("miss level", 32'(level), 2);
        tick();
        chk("miss l3", 32'(level), 3);
        tick();
        chk("miss no recapture", 32'(level), 3);
        chk("miss rd_i", 32'(rd_i), 0);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("miss clr", 32'(ovf), 0);
        strobe(24'h333333, 24'h444444);
        rx_avail_A = 1'b1;
        clr_ovf = 1'b1;
        tick();
        rx_avail_A = 1'b0;
        clr_ovf = 1'b0;
        chk("set beats clr", 32'(ovf), 1);
        tick();
        tick();
        chk("miss l6", 32'(level), 6);
        drain(6, "miss drain");

        sample(24'h0C0FFE, 24'hBEEF00);
        drain(2, "preload");
        chk("preload l1", 32'(level), 1);
        strobe(24'h777888, 24'h999AAA);
        chk("cpop start", 32'(level), 1);
        pop = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("cpop level", 32'(level), k < 3 ? 1 : 0);
            pop_chk("cpop");
        end
        pop = 1'b0;

        for (int n = 0; n < 40; n++) begin
            sample(24'($urandom), 24'($urandom));
            drain(3, "wrap");
        end
        chk("wrap empty", 32'(level), 0);

        strobe(24'h246802, 24'h135791);
        rx_avail_A = 1'b1;
        tick();
        rx_avail_A = 1'b0;
        chk("pre rst ovf", 32'(ovf), 1);
        chk("pre rst rd_q", 32'(rd_q), 1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("mid rst rd_i", 32'(rd_i), 0);
        chk("mid rst rd_q", 32'(rd_q), 0);
        chk("mid rst level", 32'(level), 0);
        chk("mid rst ovf", 32'(ovf), 0);
        exp_q.delete();
        strobe(24'hFEDCBA, 24'h012345);
        chk("post rst rd_i", 32'(rd_i), 1);
        tick();
        tick();
        tick();
        chk("post rst level", 32'(level), 3);
        drain(3, "post rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
